// File: rtl/prog_fetch_seq.sv
// Program sequencer: drives instruction-memory address, registers fetched word, handles stall/branch/halt/wrap.
// One-cycle fetch latency; stall and branch each insert one bubble; HALT exits only through reset.
module prog_fetch_seq #(
  parameter int PC_W     = 6,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 0,
  parameter int LAST_PC  = 63,
  parameter bit WRAP     = 1'b1,
  parameter int OPC_HI   = 31,
  parameter int OPC_LO   = 24,
  parameter logic [OPC_HI-OPC_LO:0] HALT_OP = 8'hFF,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_en,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [PC_W-1:0]  RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]  LAST_PC_V  = PC_W'(LAST_PC);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t               state, state_nxt;
  logic [PC_W-1:0]      pc_nxt;
  logic [INSTR_W-1:0]   instr_nxt;
  logic                 valid_nxt;
  logic                 halted_nxt;
  logic [CNT_W-1:0]     retired_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC_V;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_out   <= instr_nxt;
      instr_valid <= valid_nxt;
      halted      <= halted_nxt;
      retired     <= retired_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    instr_nxt  = instr_out;
    valid_nxt  = 1'b0;
    halted_nxt = halted;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (stall) begin
          // hold everything; a concurrent branch waits until the stall clears
        end else if (branch_en) begin
          pc_nxt = branch_target;
        end else begin
          instr_nxt = instr_in;
          valid_nxt = 1'b1;
          if (instr_in[OPC_HI:OPC_LO] == HALT_OP) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
          end else if (pc == LAST_PC_V) begin
            if (WRAP) begin
              pc_nxt = RESET_PC_V;
            end else begin
              state_nxt  = HALT;
              halted_nxt = 1'b1;
            end
          end else begin
            pc_nxt = pc + PC_W'(1);
          end
        end
      end
      HALT:    halted_nxt = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // counted on the same edge that raises instr_valid, so the count includes the word on instr_out
    retired_nxt = (valid_nxt && retired != CNT_MAX) ? retired + CNT_W'(1) : retired;
  end

endmodule

// File: tb/tb_prog_fetch_seq.sv
// Directed bench: default-parameter sequencer plus two small-program variants (wrap with narrow counter, halt at end).
module tb_prog_fetch_seq;

  logic        clk = 1'b0;
  logic        reset, stall, branch_en;
  logic [5:0]  branch_target;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] mem_a [0:63];
  logic [5:0]  pc_a;
  logic [31:0] instr_a, out_a;
  logic        valid_a, halted_a;
  logic [15:0] retired_a;

  logic [5:0]  pc_w;
  logic [31:0] out_w;
  logic        valid_w, halted_w;
  logic [2:0]  retired_w;

  logic [5:0]  pc_h;
  logic [31:0] out_h;
  logic        valid_h, halted_h;
  logic [15:0] retired_h;

  always #5 clk = ~clk;

  assign instr_a = mem_a[pc_a];

  prog_fetch_seq u_dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_target(branch_target), .instr_in(instr_a),
    .pc(pc_a), .instr_out(out_a), .instr_valid(valid_a),
    .halted(halted_a), .retired(retired_a)
  );

  prog_fetch_seq #(.LAST_PC(5), .WRAP(1'b1), .CNT_W(3)) u_wrap (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_target(branch_target), .instr_in(32'(pc_w)),
    .pc(pc_w), .instr_out(out_w), .instr_valid(valid_w),
    .halted(halted_w), .retired(retired_w)
  );

  prog_fetch_seq #(.LAST_PC(5), .WRAP(1'b0)) u_halt (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_target(branch_target), .instr_in(32'(pc_h)),
    .pc(pc_h), .instr_out(out_h), .instr_valid(valid_h),
    .halted(halted_h), .retired(retired_h)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input int offset);
    for (int i = 0; i < 64; i++) mem_a[i] = 32'(i + offset);
  endtask

  // leaves all sequencers in RUN with pc=0 and nothing delivered yet
  task automatic start();
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    fill_mem(0);
    reset = 1'b1; stall = 1'b1; branch_en = 1'b1; branch_target = 6'd9;
    step(); step();
    checks++;
    if ({pc_a, out_a, valid_a, halted_a, retired_a} !== {6'd0, 32'd0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state: pc=%0d out=%0h v=%0b h=%0b ret=%0d, want all zero", pc_a, out_a, valid_a, halted_a, retired_a);
    end
    reset = 1'b0; stall = 1'b0; branch_en = 1'b0;
    step();
    checks++;
    if ({pc_a, valid_a} !== {6'd0, 1'b0}) begin
      errors++;
      $display("FAIL idle_cycle: pc=%0d v=%0b, want pc=0 v=0", pc_a, valid_a);
    end
  endtask

  task automatic test_sequential();
    fill_mem(0);
    start();
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({out_a, valid_a, pc_a, retired_a} !== {32'(k), 1'b1, 6'(k + 1), 16'(k + 1)}) begin
        errors++;
        $display("FAIL seq_%0d: out=%0h v=%0b pc=%0d ret=%0d, want out=%0h v=1 pc=%0d ret=%0d",
                 k, out_a, valid_a, pc_a, retired_a, k, k + 1, k + 1);
      end
    end
  endtask

  task automatic test_wrap();
    fill_mem(0);
    start();
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({pc_w, out_w, valid_w, halted_w, retired_w} !==
          {6'((k + 1) % 6), 32'(k % 6), 1'b1, 1'b0, 3'((k + 1 > 7) ? 7 : k + 1)}) begin
        errors++;
        $display("FAIL wrap_%0d: pc=%0d out=%0h v=%0b h=%0b ret=%0d, want pc=%0d out=%0h v=1 h=0 ret=%0d",
                 k, pc_w, out_w, valid_w, halted_w, retired_w, (k + 1) % 6, k % 6, (k + 1 > 7) ? 7 : k + 1);
      end
      if (k == 5) begin
        checks++;
        if ({halted_h, pc_h, out_h, valid_h, retired_h} !== {1'b1, 6'd5, 32'd5, 1'b1, 16'd6}) begin
          errors++;
          $display("FAIL end_halt_edge: h=%0b pc=%0d out=%0h v=%0b ret=%0d, want h=1 pc=5 out=5 v=1 ret=6",
                   halted_h, pc_h, out_h, valid_h, retired_h);
        end
      end
    end
    checks++;
    if ({halted_h, pc_h, out_h, valid_h, retired_h} !== {1'b1, 6'd5, 32'd5, 1'b0, 16'd6}) begin
      errors++;
      $display("FAIL end_halt_hold: h=%0b pc=%0d out=%0h v=%0b ret=%0d, want h=1 pc=5 out=5 v=0 ret=6",
               halted_h, pc_h, out_h, valid_h, retired_h);
    end
  endtask

  task automatic test_halt_opcode();
    fill_mem(0);
    mem_a[3] = 32'hFF00_0000;
    start();
    step(); step(); step();
    step();
    checks++;
    if ({out_a, valid_a, halted_a, pc_a, retired_a} !== {32'hFF00_0000, 1'b1, 1'b1, 6'd3, 16'd4}) begin
      errors++;
      $display("FAIL halt_edge: out=%0h v=%0b h=%0b pc=%0d ret=%0d, want out=ff000000 v=1 h=1 pc=3 ret=4",
               out_a, valid_a, halted_a, pc_a, retired_a);
    end
    for (int k = 0; k < 20; k++) begin
      stall = (k % 5 == 1);
      branch_en = (k % 3 == 0);
      branch_target = 6'd10;
      step();
      checks++;
      if ({pc_a, valid_a, halted_a, out_a} !== {6'd3, 1'b0, 1'b1, 32'hFF00_0000}) begin
        errors++;
        $display("FAIL halt_frozen_%0d: pc=%0d v=%0b h=%0b out=%0h, want pc=3 v=0 h=1 out=ff000000",
                 k, pc_a, valid_a, halted_a, out_a);
      end
    end
    stall = 1'b0; branch_en = 1'b0;
    checks++;
    if (retired_a !== 16'd4) begin
      errors++;
      $display("FAIL halt_retired: ret=%0d, want 4", retired_a);
    end
  endtask

  task automatic test_branch();
    fill_mem(100);
    start();
    step(); step();
    branch_en = 1'b1; branch_target = 6'd10;
    step();
    branch_en = 1'b0;
    checks++;
    if ({pc_a, valid_a, out_a} !== {6'd10, 1'b0, 32'd101}) begin
      errors++;
      $display("FAIL branch_bubble: pc=%0d v=%0b out=%0d, want pc=10 v=0 out=101", pc_a, valid_a, out_a);
    end
    step();
    checks++;
    if ({out_a, valid_a, pc_a, retired_a} !== {32'd110, 1'b1, 6'd11, 16'd3}) begin
      errors++;
      $display("FAIL branch_target: out=%0d v=%0b pc=%0d ret=%0d, want out=110 v=1 pc=11 ret=3",
               out_a, valid_a, pc_a, retired_a);
    end
  endtask

  task automatic test_stall_branch();
    fill_mem(100);
    start();
    step(); step();
    stall = 1'b1; branch_en = 1'b1; branch_target = 6'd20;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({pc_a, valid_a, out_a} !== {6'd2, 1'b0, 32'd101}) begin
        errors++;
        $display("FAIL stall_hold_%0d: pc=%0d v=%0b out=%0d, want pc=2 v=0 out=101", k, pc_a, valid_a, out_a);
      end
    end
    stall = 1'b0;
    step();
    branch_en = 1'b0;
    checks++;
    if ({pc_a, valid_a} !== {6'd20, 1'b0}) begin
      errors++;
      $display("FAIL stall_then_branch: pc=%0d v=%0b, want pc=20 v=0", pc_a, valid_a);
    end
    step();
    checks++;
    if ({out_a, valid_a, pc_a, retired_a} !== {32'd120, 1'b1, 6'd21, 16'd3}) begin
      errors++;
      $display("FAIL stall_branch_resume: out=%0d v=%0b pc=%0d ret=%0d, want out=120 v=1 pc=21 ret=3",
               out_a, valid_a, pc_a, retired_a);
    end
  endtask

  task automatic test_reset_mid();
    fill_mem(0);
    start();
    repeat (7) step();
    checks++;
    if (pc_a !== 6'd7) begin
      errors++;
      $display("FAIL mid_pc_before: pc=%0d, want 7", pc_a);
    end
    reset = 1'b1; stall = 1'b1; branch_en = 1'b1; branch_target = 6'd30;
    step();
    checks++;
    if ({pc_a, out_a, valid_a, halted_a, retired_a} !== {6'd0, 32'd0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_in_stall: pc=%0d out=%0h v=%0b h=%0b ret=%0d, want all zero",
               pc_a, out_a, valid_a, halted_a, retired_a);
    end
    mem_a[3] = 32'hFF12_3456;
    start();
    repeat (6) step();
    reset = 1'b1;
    step();
    checks++;
    if ({pc_a, out_a, valid_a, halted_a, retired_a} !== {6'd0, 32'd0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_in_halt: pc=%0d out=%0h v=%0b h=%0b ret=%0d, want all zero",
               pc_a, out_a, valid_a, halted_a, retired_a);
    end
    reset = 1'b0; stall = 1'b0; branch_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
    test_reset();
    test_sequential();
    test_wrap();
    test_halt_opcode();
    test_branch();
    test_stall_branch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
